serial_word_collector: RTL and testbench

Serial-to-parallel collector placed directly downstream of the Moore sequence FSM: it samples the FSM's one-bit `output_signal` stream, one bit per qualified clock, and packs each group of WIDTH bits into a parallel word. Each completed word is presented on a valid/ready output with its population count. The collector flags words lost to back-pressure with a sticky overflow bit. Typical hookup: `bit_in` = FSM `output_signal`, `bit_en` tied high or driven by a bit-rate strobe.

---
 rtl/collector_pkg.sv | 12 +
 rtl/popcount.sv | 17 +
 rtl/serial_word_collector.sv | 116 +++++++++++
 tb/tb_serial_word_collector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/collector_pkg.sv
// Shared definitions for the serial word collector: slot state encoding and default width.
// Imported by the collector top level.
package collector_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam int COLLECTOR_WIDTH = 8;

endpackage

// File: rtl/popcount.sv
// Combinational count of set bits in a WIDTH-bit word; zero latency, no flow control.
module popcount #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] word,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(word[i]);
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Packs qualified serial bits (first bit in MSB) into WIDTH-bit words presented on valid/ready.
// Word valid the edge after its last bit; a word completing while the slot is stalled is dropped and flagged.
module serial_word_collector
  import collector_pkg::*;
#(
  parameter int WIDTH = COLLECTOR_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      bit_in,
  input  logic                      bit_en,
  output logic [WIDTH-1:0]          word_out,
  output logic [CW-1:0]             ones_count,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [$clog2(WIDTH)-1:0]  bit_count,
  output logic                      overflow
);

  localparam int             BW       = $clog2(WIDTH);
  localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);

  // Only WIDTH-1 bits need storing: the completing bit comes straight from bit_in.
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] candidate;
  logic [CW-1:0]    cand_ones;
  logic             completion;
  logic             load;
  logic             drop;
  slot_state_t      state;
  slot_state_t      state_nxt;

  assign candidate  = {sr, bit_in};
  assign completion = bit_en && (bit_count == LAST_BIT);
  assign word_valid = (state == SLOT_FULL);

  popcount #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_popcount (
    .word  (candidate),
    .count (cand_ones)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      SLOT_EMPTY: begin
        if (completion) begin
          load      = 1'b1;
          state_nxt = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (word_ready) begin
          if (completion) begin
            load = 1'b1;
          end else begin
            state_nxt = SLOT_EMPTY;
          end
        end else if (completion) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (clear) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (bit_en) begin
      sr        <= candidate[WIDTH-2:0];
      bit_count <= (bit_count == LAST_BIT) ? '0 : bit_count + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SLOT_EMPTY;
    end else if (clear) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_out   <= '0;
      ones_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      word_out   <= '0;
      ones_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        word_out   <= candidate;
        ones_count <= cand_ones;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: vector table, directed corner sequences, randomized model.
module tb_serial_word_collector;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int BW = 3;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          bit_in;
  logic          bit_en;
  logic [W-1:0]  word_out;
  logic [CW-1:0] ones_count;
  logic          word_valid;
  logic          word_ready;
  logic [BW-1:0] bit_count;
  logic          overflow;

  int n_total;
  int n_pass;

  serial_word_collector #(.WIDTH(W), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .word_out   (word_out),
    .ones_count (ones_count),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_count  (bit_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          b;
    logic          en;
    logic          rdy;
    logic          valid;
    logic [W-1:0]  word;
    logic [CW-1:0] ones;
    logic          ovf;
    logic [BW-1:0] bc;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Apply inputs, take one rising edge, settle just after it.
  task automatic step(input logic b, input logic en, input logic rdy, input logic clr);
    bit_in     = b;
    bit_en     = en;
    word_ready = rdy;
    clear      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int nbits, input logic rdy);
    for (int i = W - 1; i >= W - nbits; i--) begin
      step(w[i], 1'b1, rdy, 1'b0);
    end
  endtask

  // Randomized reference model state: bits are accumulated as an integer value.
  int           m_cnt;
  int unsigned  m_acc;
  logic         m_valid;
  logic         m_ovf;
  logic [W-1:0] m_word;

  initial begin
    logic [23:0] stream;
    int          sent;
    int          cycles;
    logic        b, en, rdy, clr;

    n_total    = 0;
    n_pass     = 0;
    reset      = 1'b0;
    clear      = 1'b0;
    bit_in     = 1'b0;
    bit_en     = 1'b0;
    word_ready = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd2};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd3};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd4};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd5};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd6};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 3'd7};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, 4'd4, 1'b0, 3'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 4'd4, 1'b0, 3'd0};

    #12;
    chk("reset_valid", 32'(word_valid), 32'd0);
    chk("reset_word", 32'(word_out), 32'd0);
    chk("reset_ones", 32'(ones_count), 32'd0);
    chk("reset_bc", 32'(bit_count), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: 1,0,1,1,0,0,1,0 then one idle cycle for the handshake.
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].b, tbl[i].en, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 32'(word_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_bc", i), 32'(bit_count), 32'(tbl[i].bc));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_word", i), 32'(word_out), 32'(tbl[i].word));
        chk($sformatf("tbl%0d_ones", i), 32'(ones_count), 32'(tbl[i].ones));
      end
    end

    // Three back-to-back words, ready held high.
    stream = 24'hA5C37E;
    for (int i = 0; i < 24; i++) begin
      step(stream[23 - i], 1'b1, 1'b1, 1'b0);
      chk($sformatf("b2b%0d_valid", i), 32'(word_valid), 32'((i % 8) == 7));
      if ((i % 8) == 7) begin
        chk($sformatf("b2b%0d_word", i), 32'(word_out), 32'((stream >> (16 - 8 * (i / 8))) & 24'hFF));
      end
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("b2b_idle_valid", 32'(word_valid), 32'd0);

    // Stall: first word held, second dropped.
    send_bits(8'h5A, 8, 1'b0);
    chk("ovf_first_valid", 32'(word_valid), 32'd1);
    chk("ovf_first_word", 32'(word_out), 32'h5A);
    chk("ovf_first_ovf", 32'(overflow), 32'd0);
    send_bits(8'h3C, 8, 1'b0);
    chk("ovf_second_valid", 32'(word_valid), 32'd1);
    chk("ovf_second_word", 32'(word_out), 32'h5A);
    chk("ovf_second_ones", 32'(ones_count), 32'd4);
    chk("ovf_second_ovf", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_accept_valid", 32'(word_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Async reset after 5 bits, with overflow still set.
    send_bits(8'hF8, 5, 1'b0);
    chk("pre_reset_bc", 32'(bit_count), 32'd5);
    reset = 1'b0;
    #1;
    chk("arst_bc", 32'(bit_count), 32'd0);
    chk("arst_valid", 32'(word_valid), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    #1;
    reset = 1'b1;
    send_bits(8'h01, 8, 1'b1);
    chk("post_reset_valid", 32'(word_valid), 32'd1);
    chk("post_reset_word", 32'(word_out), 32'h01);
    chk("post_reset_ones", 32'(ones_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Slot full and ready in the same edge as the next completion.
    send_bits(8'hAA, 8, 1'b0);
    send_bits(8'h22, 7, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("swap_valid", 32'(word_valid), 32'd1);
    chk("swap_word", 32'(word_out), 32'h22);
    chk("swap_ones", 32'(ones_count), 32'd2);
    chk("swap_ovf", 32'(overflow), 32'd0);

    // Synchronous clear after 5 bits with slot full and overflow set.
    send_bits(8'h77, 8, 1'b0);
    send_bits(8'hE0, 5, 1'b0);
    chk("pre_clear_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clear_bc", 32'(bit_count), 32'd0);
    chk("clear_valid", 32'(word_valid), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);
    send_bits(8'h01, 8, 1'b1);
    chk("post_clear_valid", 32'(word_valid), 32'd1);
    chk("post_clear_word", 32'(word_out), 32'h01);
    chk("post_clear_ones", 32'(ones_count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear coincident with a completion wins.
    send_bits(8'hFF, 7, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cmpl_valid", 32'(word_valid), 32'd0);
    chk("clr_cmpl_ovf", 32'(overflow), 32'd0);
    chk("clr_cmpl_bc", 32'(bit_count), 32'd0);

    // All-ones word with bit_en gaps; bit_count must freeze during gaps.
    sent   = 0;
    cycles = 0;
    while (sent < W && cycles < 200) begin
      en = 1'($urandom_range(0, 1));
      step(1'b1, en, 1'b0, 1'b0);
      if (en) sent++;
      cycles++;
      chk($sformatf("gap%0d_bc", cycles), 32'(bit_count), 32'(sent % W));
    end
    if (sent < W) begin
      n_total++;
      $display("FAIL gap_budget: sent %0d bits, required %0d", sent, W);
    end
    chk("gap_valid", 32'(word_valid), 32'd1);
    chk("gap_word", 32'(word_out), 32'hFF);
    chk("gap_ones", 32'(ones_count), 32'd8);

    // Randomized traffic against the reference model.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    m_cnt   = 0;
    m_acc   = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_word  = '0;
    for (int c = 0; c < 3000; c++) begin
      b   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 99) == 0);
      step(b, en, rdy, clr);
      if (clr) begin
        m_cnt   = 0;
        m_acc   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_word  = '0;
      end else begin
        logic accepted;
        accepted = m_valid && rdy;
        if (accepted) m_valid = 1'b0;
        if (en) begin
          m_acc = (m_acc * 2 + int'(b)) % (1 << W);
          m_cnt = m_cnt + 1;
          if (m_cnt == W) begin
            m_cnt = 0;
            if (!m_valid) begin
              m_valid = 1'b1;
              m_word  = W'(m_acc);
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
      end
      chk($sformatf("rnd%0d_valid", c), 32'(word_valid), 32'(m_valid));
      chk($sformatf("rnd%0d_ovf", c), 32'(overflow), 32'(m_ovf));
      chk($sformatf("rnd%0d_bc", c), 32'(bit_count), 32'(m_cnt));
      if (m_valid) begin
        chk($sformatf("rnd%0d_word", c), 32'(word_out), 32'(m_word));
        chk($sformatf("rnd%0d_ones", c), 32'(ones_count), 32'($countones(m_word)));
      end
    end
    clear = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
